// File: rtl/ofmap_fifo_pack_pkg.sv
// Shared constants and FSM state type for the ofmap write-back packer (72-bit rows -> 64-bit words).
// The 64->72 input FIFO imports the same width constants.
package ofmap_fifo_pack_pkg;

    localparam int unsigned IN_W  = 72;
    localparam int unsigned OUT_W = 64;
    localparam int unsigned BUF_W = IN_W + OUT_W;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned IDX_W = 8;

    // Index-width copies so comparisons against the fill index stay width-matched
    localparam logic [IDX_W-1:0] IDX_IN   = IDX_W'(IN_W);
    localparam logic [IDX_W-1:0] IDX_OUT  = IDX_W'(OUT_W);
    localparam logic [IDX_W-1:0] IDX_ROOM = IDX_W'(BUF_W - IN_W);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFlush,
        StDone
    } state_e;

endpackage

// File: rtl/ofmap_fifo_pack_if.sv
// Row-in / word-out handshake bundle of the ofmap packer.
// master = packer side, slave = ofmap buffer / DRAM side.
interface ofmap_fifo_pack_if;
    import ofmap_fifo_pack_pkg::*;

    logic             row_valid;
    logic             row_ready;
    logic [IN_W-1:0]  row_data;
    logic             word_valid;
    logic             word_ready;
    logic [OUT_W-1:0] word_data;
    logic             word_last;

    modport master (
        input  row_valid,
        input  row_data,
        input  word_ready,
        output row_ready,
        output word_valid,
        output word_data,
        output word_last
    );

    modport slave (
        output row_valid,
        output row_data,
        output word_ready,
        input  row_ready,
        input  word_valid,
        input  word_data,
        input  word_last
    );

endinterface

// File: rtl/ofmap_fifo_pack_shift_buf.sv
// Residue buffer: BUF_W bits filled from bit 0 upward, written at the fill index and
// drained OUT_W bits at a time from the bottom with zero fill at the top.
module ofmap_fifo_pack_shift_buf
    import ofmap_fifo_pack_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [IN_W-1:0]  wr_data,
    input  logic             shift_en,
    output logic [OUT_W-1:0] head,
    output logic [IDX_W-1:0] index
);

    logic [BUF_W-1:0] sbuf_q, sbuf_d, shifted;
    logic [IDX_W-1:0] idx_q, idx_d, idx_base;

    always_comb begin
        shifted  = sbuf_q;
        idx_base = idx_q;
        if (shift_en) begin
            shifted  = sbuf_q >> OUT_W;
            // Floor at zero: the padded flush word drains fewer than OUT_W real bits
            idx_base = (idx_q > IDX_OUT) ? (idx_q - IDX_OUT) : '0;
        end
        sbuf_d = shifted;
        idx_d  = idx_base;
        if (wr_en) begin
            sbuf_d = shifted | ({{(BUF_W - IN_W){1'b0}}, wr_data} << idx_base);
            idx_d  = idx_base + IDX_IN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sbuf_q <= '0;
            idx_q  <= '0;
        end else begin
            sbuf_q <= sbuf_d;
            idx_q  <= idx_d;
        end
    end

    assign head  = sbuf_q[OUT_W-1:0];
    assign index = idx_q;

endmodule

// File: rtl/ofmap_fifo_pack.sv
// Ofmap write-back packer: 72-bit rows in, 64-bit DRAM words out, zero-padded flush.
// Optional PACK_CHECKSUM_EN adds a running XOR of every emitted word.
module ofmap_fifo_pack
    import ofmap_fifo_pack_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    flush,
    ofmap_fifo_pack_if.master       bus,
    output logic                    busy,
    output logic                    done,
    output logic [CNT_W-1:0]        rows_in,
`ifdef PACK_CHECKSUM_EN
    output logic [OUT_W-1:0]        checksum,
`endif
    output logic [CNT_W-1:0]        words_out
);

    state_e           state_q;
    logic [CNT_W-1:0] rows_q, words_q;
    logic [IDX_W-1:0] index;
    logic [OUT_W-1:0] head;
    logic             row_acc, word_fire, clr;

    assign clr       = (state_q == StIdle) && start;
    assign row_acc   = bus.row_valid && bus.row_ready;
    assign word_fire = bus.word_valid && bus.word_ready;

    // All handshake outputs decode registers only; no row_valid -> word_valid path
    assign bus.row_ready  = (state_q == StRun) && (index <= IDX_ROOM);
    assign bus.word_valid = (index >= IDX_OUT) || ((state_q == StFlush) && (index != '0));
    assign bus.word_last  = (state_q == StFlush) && (index != '0) && (index <= IDX_OUT);
    assign bus.word_data  = head;

    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign rows_in   = rows_q;
    assign words_out = words_q;

    ofmap_fifo_pack_shift_buf u_pack_shift_buf (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .wr_en    (row_acc),
        .wr_data  (bus.row_data),
        .shift_en (word_fire),
        .head     (head),
        .index    (index)
    );

`ifdef PACK_CHECKSUM_EN
    logic [OUT_W-1:0] csum_q;
    assign checksum = csum_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            csum_q <= '0;
        end else if (word_fire) begin
            csum_q <= csum_q ^ head;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            rows_q  <= '0;
            words_q <= '0;
        end else begin
            if (clr) begin
                rows_q  <= '0;
                words_q <= '0;
            end else begin
                if (row_acc) begin
                    rows_q <= rows_q + CNT_W'(1);
                end
                if (word_fire) begin
                    words_q <= words_q + CNT_W'(1);
                end
            end
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (flush) begin
                        state_q <= StFlush;
                    end
                end
                StFlush: begin
                    // Leave as soon as the final word fires, or at once if nothing is left
                    if ((index == '0) || (word_fire && bus.word_last)) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ofmap_fifo_pack.sv
// Directed self-checking bench for ofmap_fifo_pack; define PACK_CHECKSUM_EN to cover the checksum build.
module tb_ofmap_fifo_pack;
    import ofmap_fifo_pack_pkg::*;

    logic             clk = 1'b0;
    logic             rst, start, flush;
    logic             busy, done;
    logic [CNT_W-1:0] rows_in, words_out;
`ifdef PACK_CHECKSUM_EN
    logic [OUT_W-1:0] checksum;
`endif

    ofmap_fifo_pack_if pif ();

    ofmap_fifo_pack dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .flush     (flush),
        .bus       (pif),
        .busy      (busy),
        .done      (done),
        .rows_in   (rows_in),
`ifdef PACK_CHECKSUM_EN
        .checksum  (checksum),
`endif
        .words_out (words_out)
    );

    always #5 clk = ~clk;

    int               n_vec = 0;
    int               n_err = 0;
    logic [IN_W-1:0]  rows [0:7];
    logic [OUT_W-1:0] cap_data [0:15];
    logic             cap_last [0:15];
    int               cap_cyc [0:15];
    int               n_cap, done_cyc, stall_cycles, stable_err, rows_at_release;
    bit               timed_out;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: rows concatenated LSB-first into one bit stream, zero beyond the end
    function automatic logic [OUT_W-1:0] model_word(input int nrows, input int j);
        logic [1023:0] s;
        s = '0;
        for (int i = 0; i < nrows; i++) s[IN_W*i +: IN_W] = rows[i];
        return s[OUT_W*j +: OUT_W];
    endfunction

    function automatic logic [IN_W-1:0] mk_row(input int i);
        logic [IN_W-1:0] r;
        for (int k = 0; k < 9; k++) r[8*k +: 8] = 8'(16 * i + k + 1);
        return r;
    endfunction

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Streams nrows rows, flushes once all are accepted, captures fired words until done
    task automatic run_layer(input int nrows);
        int               r = 0;
        int               cyc = 0;
        bit               fsent = 0;
        logic             held_v = 1'b0;
        logic [OUT_W-1:0] held = '0;
        n_cap = 0;
        stable_err = 0;
        rows_at_release = -1;
        while (!done && cyc < 300) begin
            if (cyc == stall_cycles) rows_at_release = r;
            pif.row_valid  = (r < nrows);
            pif.row_data   = (r < nrows) ? rows[r] : '0;
            flush          = (r >= nrows) && !fsent;
            pif.word_ready = (cyc >= stall_cycles);
            if (held_v && pif.word_data !== held) stable_err++;
            held_v = pif.word_valid && !pif.word_ready;
            held   = pif.word_data;
            if (pif.row_valid && pif.row_ready) r++;
            if (pif.word_valid && pif.word_ready && n_cap < 16) begin
                cap_data[n_cap] = pif.word_data;
                cap_last[n_cap] = pif.word_last;
                cap_cyc[n_cap]  = cyc;
                n_cap++;
            end
            if (flush) fsent = 1;
            tick();
            cyc++;
        end
        done_cyc       = cyc;
        timed_out      = !done;
        pif.row_valid  = 1'b0;
        pif.word_ready = 1'b0;
        flush          = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; flush = 1'b0;
        pif.row_valid = 1'b0; pif.row_data = '0; pif.word_ready = 1'b0;
        tick();
        tick();
        n_vec++;
        if ({busy, done, pif.row_ready, pif.word_valid, pif.word_last} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b want 00000",
                     {busy, done, pif.row_ready, pif.word_valid, pif.word_last});
        end
        n_vec++;
        if (pif.word_data !== 64'h0) begin
            n_err++; $display("FAIL reset_word_data: got %h want 0", pif.word_data);
        end
        n_vec++;
        if (rows_in !== 16'd0 || words_out !== 16'd0) begin
            n_err++; $display("FAIL reset_counters: got %0d/%0d want 0/0", rows_in, words_out);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_full_layer();
        for (int i = 0; i < 8; i++) rows[i] = mk_row(i);
        stall_cycles = 0;
        do_start();
        run_layer(8);
        n_vec++;
        if (timed_out) begin n_err++; $display("FAIL full_timeout: got no done want done"); end
        n_vec++;
        if (n_cap !== 9) begin n_err++; $display("FAIL full_nwords: got %0d want 9", n_cap); end
        for (int j = 0; j < 9 && j < n_cap; j++) begin
            n_vec++;
            if (cap_data[j] !== model_word(8, j) || cap_last[j] !== (j == 8)) begin
                n_err++;
                $display("FAIL full_word%0d: got %h last=%b want %h last=%b", j, cap_data[j],
                         cap_last[j], model_word(8, j), (j == 8));
            end
        end
        n_vec++;
        if (n_cap > 0 && done_cyc !== cap_cyc[n_cap-1] + 1) begin
            n_err++;
            $display("FAIL full_done_lat: got cyc %0d want %0d", done_cyc, cap_cyc[n_cap-1] + 1);
        end
        n_vec++;
        if (rows_in !== 16'd8 || words_out !== 16'd9) begin
            n_err++; $display("FAIL full_counters: got %0d/%0d want 8/9", rows_in, words_out);
        end
`ifdef PACK_CHECKSUM_EN
        begin
            logic [OUT_W-1:0] x;
            x = '0;
            for (int j = 0; j < 9; j++) x ^= model_word(8, j);
            n_vec++;
            if (checksum !== x) begin
                n_err++; $display("FAIL full_checksum: got %h want %h", checksum, x);
            end
        end
`endif
        tick();
        n_vec++;
        if (done !== 1'b0 || busy !== 1'b0 || rows_in !== 16'd8 || words_out !== 16'd9) begin
            n_err++;
            $display("FAIL full_after_done: got done=%b busy=%b cnt=%0d/%0d want 0 0 8/9",
                     done, busy, rows_in, words_out);
        end
    endtask

    task automatic test_single_row();
        rows[0] = 72'hA5_0123456789ABCDEF;
        stall_cycles = 0;
        do_start();
        run_layer(1);
        n_vec++;
        if (n_cap !== 2 || timed_out) begin
            n_err++; $display("FAIL single_nwords: got %0d tmo=%b want 2 tmo=0", n_cap, timed_out);
        end else begin
            n_vec++;
            if (cap_data[0] !== 64'h0123456789ABCDEF || cap_last[0] !== 1'b0 || cap_cyc[0] !== 1) begin
                n_err++;
                $display("FAIL single_word0: got %h last=%b cyc=%0d want 0123456789abcdef 0 1",
                         cap_data[0], cap_last[0], cap_cyc[0]);
            end
            n_vec++;
            if (cap_data[1] !== 64'h00000000000000A5 || cap_last[1] !== 1'b1 || cap_cyc[1] !== 2) begin
                n_err++;
                $display("FAIL single_word1: got %h last=%b cyc=%0d want 00000000000000a5 1 2",
                         cap_data[1], cap_last[1], cap_cyc[1]);
            end
            n_vec++;
            if (done_cyc !== 3) begin
                n_err++; $display("FAIL single_done: got cyc %0d want 3", done_cyc);
            end
        end
        tick();
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 8; i++) rows[i] = mk_row(i + 3);
        stall_cycles = 10;
        do_start();
        run_layer(8);
        n_vec++;
        if (rows_at_release !== 1) begin
            n_err++; $display("FAIL bp_rows_stalled: got %0d want 1", rows_at_release);
        end
        n_vec++;
        if (stable_err !== 0) begin
            n_err++; $display("FAIL bp_stable: got %0d changes want 0", stable_err);
        end
        n_vec++;
        if (n_cap !== 9 || cap_cyc[0] !== 10) begin
            n_err++;
            $display("FAIL bp_release: got n=%0d first=%0d want n=9 first=10", n_cap, cap_cyc[0]);
        end
        for (int j = 0; j < 9 && j < n_cap; j++) begin
            n_vec++;
            if (cap_data[j] !== model_word(8, j)) begin
                n_err++;
                $display("FAIL bp_word%0d: got %h want %h", j, cap_data[j], model_word(8, j));
            end
        end
        tick();
    endtask

    task automatic test_empty_flush();
        stall_cycles = 0;
        do_start();
        run_layer(0);
        n_vec++;
        if (n_cap !== 0 || timed_out || done_cyc !== 2) begin
            n_err++;
            $display("FAIL empty_flush: got n=%0d tmo=%b done_cyc=%0d want 0 0 2",
                     n_cap, timed_out, done_cyc);
        end
        n_vec++;
        if (words_out !== 16'd0 || rows_in !== 16'd0) begin
            n_err++; $display("FAIL empty_counters: got %0d/%0d want 0/0", rows_in, words_out);
        end
        tick();
    endtask

    task automatic test_mid_reset();
        int r = 0;
        for (int i = 0; i < 8; i++) rows[i] = mk_row(7 - i);
        do_start();
        for (int cyc = 0; cyc < 40; cyc++) begin
            pif.row_valid  = (r < 5);
            pif.row_data   = (r < 5) ? rows[r] : '0;
            pif.word_ready = 1'b1;
            if (pif.row_valid && pif.row_ready) r++;
            tick();
            if (r == 5 && !pif.word_valid) break;
        end
        pif.row_valid = 1'b0;
        // 360 bits in, 5 words out -> 40 bits of residue
        n_vec++;
        if (rows_in !== 16'd5 || words_out !== 16'd5 || pif.word_valid !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_pre: got %0d/%0d wv=%b busy=%b want 5/5 0 1",
                     rows_in, words_out, pif.word_valid, busy);
        end
        do_start();
        n_vec++;
        if (rows_in !== 16'd5 || pif.row_ready !== 1'b1) begin
            n_err++;
            $display("FAIL start_in_run: got rows=%0d rr=%b want 5 1", rows_in, pif.row_ready);
        end
        rst = 1'b1;
        tick();
        n_vec++;
        if (busy !== 1'b0 || pif.word_valid !== 1'b0 || pif.row_ready !== 1'b0 ||
            rows_in !== 16'd0 || words_out !== 16'd0) begin
            n_err++;
            $display("FAIL midrst_post: got busy=%b wv=%b rr=%b cnt=%0d/%0d want 0 0 0 0/0",
                     busy, pif.word_valid, pif.row_ready, rows_in, words_out);
        end
        rst = 1'b0;
        tick();
        stall_cycles = 0;
        do_start();
        run_layer(1);
        n_vec++;
        if (n_cap !== 2 || cap_data[0] !== model_word(1, 0) || cap_data[1] !== model_word(1, 1)) begin
            n_err++;
            $display("FAIL midrst_restart: got n=%0d %h %h want 2 %h %h", n_cap, cap_data[0],
                     cap_data[1], model_word(1, 0), model_word(1, 1));
        end
        n_vec++;
        if (rows_in !== 16'd1 || words_out !== 16'd2) begin
            n_err++; $display("FAIL midrst_counters: got %0d/%0d want 1/2", rows_in, words_out);
        end
        tick();
    endtask

`ifdef PACK_CHECKSUM_EN
    task automatic test_checksum();
        logic [OUT_W-1:0] x;
        for (int i = 0; i < 8; i++) rows[i] = 72'h010203040506070809;
        stall_cycles = 0;
        do_start();
        run_layer(8);
        x = '0;
        for (int j = 0; j < 9; j++) x ^= model_word(8, j);
        n_vec++;
        if (checksum !== x || !done) begin
            n_err++; $display("FAIL checksum: got %h done=%b want %h done=1", checksum, done, x);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_full_layer();
        test_single_row();
        test_backpressure();
        test_empty_flush();
        test_mid_reset();
`ifdef PACK_CHECKSUM_EN
        test_checksum();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

endmodule
